id_stage: RTL

Instruction-decode stage of the five-stage MIPS pipeline: it consumes the IF/ID register (`if_id_instruction`, `if_id_pc_next`) and reads the 32×32 register file. It decodes control signals, resolves branches and jumps in ID, and detects hazards. It drives `stall`, `flush_if`, `jump_taken`, `branch_taken`, `pc_jump` and `pc_branch` back to the fetch stage, and registers the ID/EX pipeline bundle for execute.

---
 rtl/mips_pkg.sv | 79 +++++++
 rtl/id_stage_regfile.sv | 53 +++++
 rtl/id_stage.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS decode definitions: opcodes, funct codes, ALU encodings and the
// control/ID-EX bundle types used by the ID stage.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [4:0]  REG_ZERO  = 5'd0;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4
  } alu_ctrl_e;

  // Decoded controls plus the hazard/redirect qualifiers of the ID instruction
  typedef struct packed {
    logic      reg_write;
    logic      mem_to_reg;
    logic      mem_read;
    logic      mem_write;
    logic      alu_src;
    alu_ctrl_e alu_ctrl;
    logic      uses_rt;
    logic      is_branch;
    logic      is_bne;
    logic      is_jump;
    logic      dest_rd;
    logic      dest_rt;
  } ctrl_t;

  typedef struct packed {
    logic        reg_write;
    logic        mem_to_reg;
    logic        mem_read;
    logic        mem_write;
    logic        alu_src;
    logic [2:0]  alu_ctrl;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [31:0] pc_next;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
  } idex_t;

  localparam ctrl_t CTRL_NOP    = ctrl_t'({$bits(ctrl_t){1'b0}});
  localparam idex_t IDEX_BUBBLE = idex_t'({$bits(idex_t){1'b0}});

  function automatic ctrl_t rtype_ctrl(input alu_ctrl_e op);
    ctrl_t c;
    c           = CTRL_NOP;
    c.reg_write = 1'b1;
    c.uses_rt   = 1'b1;
    c.dest_rd   = 1'b1;
    c.alu_ctrl  = op;
    return c;
  endfunction

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/id_stage_regfile.sv
// 32x32 register file: two read ports, one write port, $0 hardwired to zero,
// and a same-cycle write-to-read bypass.
module regfile
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd1,
  output logic [31:0] rd2,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd
);

  logic [31:0] regs_r [32];
  logic        wr_en_s;

  assign wr_en_s = we & (wa != REG_ZERO);

  // Register array storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        regs_r[i] <= 32'd0;
      end
    end else if (wr_en_s) begin
      regs_r[wa] <= wd;
    end
  end

  // Read ports with zero register and write bypass
  always_comb begin
    rd1 = 32'd0;
    rd2 = 32'd0;
    if (ra1 == REG_ZERO) begin
      rd1 = 32'd0;
    end else if (wr_en_s && (wa == ra1)) begin
      rd1 = wd;
    end else begin
      rd1 = regs_r[ra1];
    end
    if (ra2 == REG_ZERO) begin
      rd2 = 32'd0;
    end else if (wr_en_s && (wa == ra2)) begin
      rd2 = wd;
    end else begin
      rd2 = regs_r[ra2];
    end
  end

endmodule

// File: rtl/id_stage.sv
// MIPS instruction-decode stage: decode, ID-stage branch/jump resolution,
// hazard detection and the ID/EX register. Define BRANCH_FWD_EN to forward
// the MEM-stage ALU result into the branch comparator instead of stalling.
module id_stage
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] if_id_instruction,
  input  logic [31:0] if_id_pc_next,
  input  logic        wb_reg_write,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  input  logic        ex_mem_reg_write,
  input  logic        ex_mem_mem_read,
  input  logic [4:0]  ex_mem_rd,
  input  logic [31:0] ex_mem_alu_result,
  output logic        stall,
  output logic        flush_if,
  output logic        jump_taken,
  output logic        branch_taken,
  output logic [31:0] pc_jump,
  output logic [31:0] pc_branch,
  output logic        id_ex_reg_write,
  output logic        id_ex_mem_to_reg,
  output logic        id_ex_mem_read,
  output logic        id_ex_mem_write,
  output logic        id_ex_alu_src,
  output logic [2:0]  id_ex_alu_ctrl,
  output logic [31:0] id_ex_rs_data,
  output logic [31:0] id_ex_rt_data,
  output logic [31:0] id_ex_imm,
  output logic [31:0] id_ex_pc_next,
  output logic [4:0]  id_ex_rs,
  output logic [4:0]  id_ex_rt,
  output logic [4:0]  id_ex_rd
);

  logic [5:0]  opcode_s;
  logic [5:0]  funct_s;
  logic [4:0]  rs_s;
  logic [4:0]  rt_s;
  logic [4:0]  rd_field_s;
  logic [4:0]  dest_s;
  logic [31:0] imm_s;
  logic [31:0] rs_val_s;
  logic [31:0] rt_val_s;
  logic [31:0] cmp_a_s;
  logic [31:0] cmp_b_s;
  ctrl_t       ctrl_s;
  logic        alu_fwd_ok_s;
  logic        load_use_s;
  logic        br_ex_s;
  logic        br_mem_ld_s;
  logic        br_mem_alu_s;
  logic        stall_s;
  logic        taken_cmp_s;
  idex_t       idex_d_s;
  idex_t       idex_r;

  assign opcode_s   = if_id_instruction[31:26];
  assign rs_s       = if_id_instruction[25:21];
  assign rt_s       = if_id_instruction[20:16];
  assign rd_field_s = if_id_instruction[15:11];
  assign funct_s    = if_id_instruction[5:0];
  assign imm_s      = sext16(if_id_instruction[15:0]);

  regfile u_regfile (
    .clk   (clk),
    .rst_n (rst_n),
    .ra1   (rs_s),
    .ra2   (rt_s),
    .rd1   (rs_val_s),
    .rd2   (rt_val_s),
    .we    (wb_reg_write),
    .wa    (wb_rd),
    .wd    (wb_data)
  );

  // Instruction decode; unsupported encodings fall through to all-zero controls
  always_comb begin
    ctrl_s = CTRL_NOP;
    case (opcode_s)
      OP_RTYPE: begin
        case (funct_s)
          FN_ADD:  ctrl_s = rtype_ctrl(ALU_ADD);
          FN_SUB:  ctrl_s = rtype_ctrl(ALU_SUB);
          FN_AND:  ctrl_s = rtype_ctrl(ALU_AND);
          FN_OR:   ctrl_s = rtype_ctrl(ALU_OR);
          FN_SLT:  ctrl_s = rtype_ctrl(ALU_SLT);
          default: ctrl_s = CTRL_NOP;
        endcase
      end
      OP_ADDI: begin
        ctrl_s.reg_write = 1'b1;
        ctrl_s.alu_src   = 1'b1;
        ctrl_s.dest_rt   = 1'b1;
      end
      OP_LW: begin
        ctrl_s.reg_write  = 1'b1;
        ctrl_s.mem_to_reg = 1'b1;
        ctrl_s.mem_read   = 1'b1;
        ctrl_s.alu_src    = 1'b1;
        ctrl_s.dest_rt    = 1'b1;
      end
      OP_SW: begin
        ctrl_s.mem_write = 1'b1;
        ctrl_s.alu_src   = 1'b1;
        ctrl_s.uses_rt   = 1'b1;
        ctrl_s.dest_rt   = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        ctrl_s.is_branch = 1'b1;
        ctrl_s.is_bne    = (opcode_s == OP_BNE);
        ctrl_s.uses_rt   = 1'b1;
        ctrl_s.alu_ctrl  = ALU_SUB;
        ctrl_s.dest_rt   = 1'b1;
      end
      OP_J: begin
        ctrl_s.is_jump = 1'b1;
      end
      default: ctrl_s = CTRL_NOP;
    endcase
  end

  // Final destination index
  always_comb begin
    dest_s = REG_ZERO;
    if (ctrl_s.dest_rd) begin
      dest_s = rd_field_s;
    end else if (ctrl_s.dest_rt) begin
      dest_s = rt_s;
    end else begin
      dest_s = REG_ZERO;
    end
  end

  assign alu_fwd_ok_s = ex_mem_reg_write & ~ex_mem_mem_read & (ex_mem_rd != REG_ZERO);

`ifdef BRANCH_FWD_EN
  // Branch comparator operands, taking a MEM-stage ALU result when it matches
  always_comb begin
    cmp_a_s = rs_val_s;
    cmp_b_s = rt_val_s;
    if (alu_fwd_ok_s && (ex_mem_rd == rs_s)) begin
      cmp_a_s = ex_mem_alu_result;
    end else begin
      cmp_a_s = rs_val_s;
    end
    if (alu_fwd_ok_s && (ex_mem_rd == rt_s)) begin
      cmp_b_s = ex_mem_alu_result;
    end else begin
      cmp_b_s = rt_val_s;
    end
  end
  assign br_mem_alu_s = 1'b0;
`else
  logic unused_alu_result_s;
  assign unused_alu_result_s = ^ex_mem_alu_result;
  assign cmp_a_s      = rs_val_s;
  assign cmp_b_s      = rt_val_s;
  // Without forwarding, wait one cycle and pick the value up from the WB bypass
  assign br_mem_alu_s = ctrl_s.is_branch & alu_fwd_ok_s &
                        ((ex_mem_rd == rs_s) | (ex_mem_rd == rt_s));
`endif

  assign load_use_s  = id_ex_mem_read & (id_ex_rd != REG_ZERO) &
                       ((id_ex_rd == rs_s) | (ctrl_s.uses_rt & (id_ex_rd == rt_s)));
  assign br_ex_s     = ctrl_s.is_branch & id_ex_reg_write & (id_ex_rd != REG_ZERO) &
                       ((id_ex_rd == rs_s) | (id_ex_rd == rt_s));
  assign br_mem_ld_s = ctrl_s.is_branch & ex_mem_mem_read & (ex_mem_rd != REG_ZERO) &
                       ((ex_mem_rd == rs_s) | (ex_mem_rd == rt_s));
  assign stall_s     = load_use_s | br_ex_s | br_mem_ld_s | br_mem_alu_s;

  assign taken_cmp_s  = ctrl_s.is_bne ? (cmp_a_s != cmp_b_s) : (cmp_a_s == cmp_b_s);
  assign stall        = stall_s;
  assign branch_taken = ~stall_s & ctrl_s.is_branch & taken_cmp_s;
  assign jump_taken   = ~stall_s & ctrl_s.is_jump;
  assign flush_if     = branch_taken | jump_taken;
  assign pc_branch    = if_id_pc_next + {imm_s[29:0], 2'b00};
  assign pc_jump      = {if_id_pc_next[31:28], if_id_instruction[25:0], 2'b00};

  // Next ID/EX bundle: decoded instruction, or a bubble while stalled
  always_comb begin
    idex_d_s = IDEX_BUBBLE;
    if (stall_s) begin
      idex_d_s = IDEX_BUBBLE;
    end else begin
      idex_d_s.reg_write  = ctrl_s.reg_write;
      idex_d_s.mem_to_reg = ctrl_s.mem_to_reg;
      idex_d_s.mem_read   = ctrl_s.mem_read;
      idex_d_s.mem_write  = ctrl_s.mem_write;
      idex_d_s.alu_src    = ctrl_s.alu_src;
      idex_d_s.alu_ctrl   = ctrl_s.alu_ctrl;
      idex_d_s.rs_data    = rs_val_s;
      idex_d_s.rt_data    = rt_val_s;
      idex_d_s.imm        = imm_s;
      idex_d_s.pc_next    = if_id_pc_next;
      idex_d_s.rs         = rs_s;
      idex_d_s.rt         = rt_s;
      idex_d_s.rd         = dest_s;
    end
  end

  // ID/EX pipeline register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idex_r <= IDEX_BUBBLE;
    end else begin
      idex_r <= idex_d_s;
    end
  end

  assign id_ex_reg_write  = idex_r.reg_write;
  assign id_ex_mem_to_reg = idex_r.mem_to_reg;
  assign id_ex_mem_read   = idex_r.mem_read;
  assign id_ex_mem_write  = idex_r.mem_write;
  assign id_ex_alu_src    = idex_r.alu_src;
  assign id_ex_alu_ctrl   = idex_r.alu_ctrl;
  assign id_ex_rs_data    = idex_r.rs_data;
  assign id_ex_rt_data    = idex_r.rt_data;
  assign id_ex_imm        = idex_r.imm;
  assign id_ex_pc_next    = idex_r.pc_next;
  assign id_ex_rs         = idex_r.rs;
  assign id_ex_rt         = idex_r.rt;
  assign id_ex_rd         = idex_r.rd;

endmodule
